// File: rtl/regfile_dualport.sv
// regfile_dualport: DEPTH x WIDTH register file, two async read ports, one write port, optional bypass, pending-write scoreboard
module regfile_dualport #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int AW = $clog2(DEPTH),
  parameter int BYPASS = 0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  input  logic [AW-1:0]    writenum,
  input  logic             write,
  input  logic [AW-1:0]    readnum_a,
  input  logic [AW-1:0]    readnum_b,
  output logic [WIDTH-1:0] data_out_a,
  output logic [WIDTH-1:0] data_out_b,
  input  logic             sb_set,
  input  logic [AW-1:0]    sb_setnum,
  output logic             busy_a,
  output logic             busy_b,
  output logic             any_busy,
  output logic [DEPTH-1:0] pend_vec
);
  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] pend;
  logic hit_a, hit_b, keep;
  // storage and scoreboard; a set on the written register wins over the clear
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      regs <= '{default: RESET_VAL};
      pend <= '0;
    end else begin
      if (write) regs[writenum] <= data_in;
      pend <= (pend & ~(DEPTH'(write) << writenum)) | (DEPTH'(sb_set) << sb_setnum);
    end
  // combinational reads with optional forwarding of the in-flight write, suppressed during reset
  always_comb begin
    keep = sb_set && sb_setnum == writenum;
    hit_a = BYPASS != 0 && rst_n && write && readnum_a == writenum;
    hit_b = BYPASS != 0 && rst_n && write && readnum_b == writenum;
    data_out_a = hit_a ? data_in : regs[readnum_a];
    data_out_b = hit_b ? data_in : regs[readnum_b];
    busy_a = pend[readnum_a] && !(hit_a && !keep);
    busy_b = pend[readnum_b] && !(hit_b && !keep);
    any_busy = |pend;
    pend_vec = pend;
  end
endmodule
